// File: rtl/axi_typedefs.sv
// Shared AXI response/burst definitions and the next-beat address rule.
// Used by the write responder and by master-side checkers; pure combinational helpers.
package axi_typedefs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  // Computed at 64 bits; callers truncate to their own address width.
  typedef logic [63:0] axi_addr_t;

  function automatic axi_addr_t axi_next_addr(input axi_addr_t addr, input logic [3:0] len,
                                              input logic [2:0] size, input burst_e burst);
    axi_addr_t n;
    axi_addr_t b;
    n = 64'(1) << size;
    b = 64'({1'b0, len} + 5'd1) << size;
    case (burst)
      BURST_INCR: axi_next_addr = addr + n;
      BURST_WRAP: axi_next_addr = (addr & ~(b - 64'd1)) | ((addr + n) & (b - 64'd1));
      default:    axi_next_addr = addr;
    endcase
  endfunction

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Beat address/count tracker: loads on AW handshake, steps once per accepted W beat.
// Zero-latency outputs from registers; no handshaking of its own.
module axi_wr_addr_gen
  import axi_typedefs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last_beat,
  output logic              wrap_len_err
);

  logic [3:0] len_q;
  logic [3:0] cnt_q;
  logic [2:0] size_q;
  burst_e     burst_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_addr <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
    end else if (load) begin
      cur_addr <= awaddr;
      len_q    <= awlen;
      cnt_q    <= '0;
      size_q   <= awsize;
      burst_q  <= burst_e'(awburst);
    end else if (step) begin
      cur_addr <= ADDR_W'(axi_next_addr(64'(cur_addr), len_q, size_q, burst_q));
      cnt_q    <= cnt_q + 4'd1;
    end
  end

  assign last_beat    = (cnt_q == len_q);
  assign wrap_len_err = (burst_q == BURST_WRAP) && !wrap_len_ok(len_q);

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write responder over an internal word memory; one burst at a time, one B per burst.
// AW->wready 1 cycle, last W->bvalid 1 cycle; B held until bready, AW/W stalled meanwhile.
module axi_wr_slave
  import axi_typedefs::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_W-1:0]              awid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [3:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic              aw_hs, w_hs, burst_end;
  logic              last_beat, wrap_len_err, beat_oob, beat_err, aw_err;
  logic              err_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  axi_wr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .load        (aw_hs),
    .step        (w_hs),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .awburst     (awburst),
    .cur_addr    (cur_addr),
    .last_beat   (last_beat),
    .wrap_len_err(wrap_len_err)
  );

  // Ready/valid are functions of state only, so nothing combinationally follows the master's valids.
  always_comb begin
    state_d   = state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready = 1'b1;
        aw_hs   = awvalid;
        if (awvalid) state_d = ST_DATA;
      end
      ST_DATA: begin
        wready    = 1'b1;
        w_hs      = wvalid;
        burst_end = wvalid && (wlast || last_beat);
        if (burst_end) state_d = ST_RESP;
      end
      ST_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign aw_err   = (int'(awsize) > LANE_W) || (awburst == 2'b11);
  assign beat_oob = (cur_addr >> (LANE_W + IDX_W)) != '0;
  assign word_idx = cur_addr[LANE_W +: IDX_W];
  assign beat_err = beat_oob || (wlast != last_beat) || wrap_len_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        bid_q <= awid;
        err_q <= aw_err;
      end else if (w_hs) begin
        err_q <= err_q || beat_err;
        if (burst_end) bresp_q <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory contents survive reset; out-of-range beats are dropped, not aliased.
  always_ff @(posedge aclk) begin
    if (w_hs && !beat_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];
  assign bid       = bid_q;
  assign bresp     = bresp_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Bench for axi_wr_slave: directed bursts plus randomized bursts against a byte-level memory model.
`timescale 1ns/1ps
module tb_axi_wr_slave;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_WORDS = 256;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [3:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [7:0]        dbg_addr = '0;
  logic [DATA_W-1:0] dbg_rdata;

  always #5 aclk = ~aclk;

  axi_wr_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [256];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference beat address from the burst definitions, using plain division for WRAP.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint la, n, b, base;
    la = longint'(a);
    n  = longint'(1) << size;
    if (burst == 1) return 32'(la + i * n);
    if (burst == 2) begin
      b    = (len + 1) * n;
      base = (la / b) * b;
      return 32'(base + ((la % b) + i * n) % b);
    end
    return a;
  endfunction

  task automatic mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_word(input int idx, input string tag);
    dbg_addr = 8'(idx);
    tick();
    n_cmp++;
    if (dbg_rdata !== mdl[idx]) begin
      n_bad++;
      $display("FAIL %s mem[%0d] got %h want %h", tag, idx, dbg_rdata, mdl[idx]);
    end
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int wlast_at,
                          input int stall, input string tag);
    int          nb;
    bit          exp_err, ok;
    logic [1:0]  exp_resp;
    logic [31:0] ba;
    int          touched[$];
    nb = ((wlast_at < len) ? wlast_at : len) + 1;
    exp_err = (size > 2) || (burst == 3) || (wlast_at != len) ||
              ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = awready;
      tick();
    end
    awvalid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s aw_handshake timed out", tag);
      return;
    end
    n_cmp++;
    if (wready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_wready got %b want 1", tag, wready);
    end
    for (int i = 0; i < nb; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at); wvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        ok = wready;
        if (ok && i == nb - 1) begin
          n_cmp++;
          if (bvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s bvalid_before_last got %b want 0", tag, bvalid);
          end
        end
        tick();
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s w_beat %0d timed out", tag, i);
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
      ba = beat_addr(addr, len, size, burst, i);
      if (ba >= 32'h400) exp_err = 1'b1;
      else begin
        mdl_write(int'(ba >> 2), wd[i], ws[i]);
        touched.push_back(int'(ba >> 2));
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_resp = exp_err ? 2'b10 : 2'b00;
    n_cmp++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== exp_resp) begin
      n_bad++;
      $display("FAIL %s b_channel got v=%b id=%h resp=%b want v=1 id=%h resp=%b",
               tag, bvalid, bid, bresp, id, exp_resp);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      n_cmp++;
      if (bvalid !== 1'b1 || bid !== id || bresp !== exp_resp || awready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s b_stall cycle %0d got v=%b id=%h resp=%b awready=%b want 1 %h %b 0",
                 tag, s, bvalid, bid, bresp, awready, id, exp_resp);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after_bready got bvalid=%b awready=%b want 0 1", tag, bvalid, awready);
    end
    foreach (touched[k]) check_word(touched[k], tag);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 || bid !== 4'h0) begin
      n_bad++;
      $display("FAIL reset outputs got awready=%b wready=%b bvalid=%b bresp=%b bid=%h want 1 0 0 00 0",
               awready, wready, bvalid, bresp, bid);
    end
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_init();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(4'(k), 32'(k * 64), 15, 2, 1, 15, 0, "init");
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    wr_burst(4'h3, 32'h10, 3, 2, 1, 3, 0, "incr");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0B0_0000 + 32'(i); ws[i] = 4'hF; end
    wr_burst(4'h7, 32'h38, 3, 2, 2, 3, 0, "wrap");
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'h0; end
    wr_burst(4'h8, 32'h40, 2, 2, 2, 2, 0, "wrap_len2");
  endtask

  task automatic test_fixed();
    wd[0] = 32'h1111_2222; ws[0] = 4'h3;
    wd[1] = 32'h3333_4444; ws[1] = 4'hC;
    wr_burst(4'h9, 32'h20, 1, 2, 0, 1, 0, "fixed");
  endtask

  task automatic test_oob();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
    wr_burst(4'hA, 32'h3F8, 3, 2, 1, 3, 0, "oob");
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hD00D_0000 + 32'(i); ws[i] = 4'hF; end
    wr_burst(4'hB, 32'h100, 3, 2, 1, 1, 0, "early_wlast");
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wr_burst(4'hC, 32'h180, 1, 2, 1, 1, 10, "bready_stall");
  endtask

  task automatic test_reset_mid();
    bit ok;
    awid = 4'h5; awaddr = 32'h80; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin ok = awready; tick(); end
    awvalid = 1'b0;
    wdata = $urandom; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    if (ok) begin
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin ok = wready; tick(); end
    end
    wvalid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL reset_mid setup handshake timed out");
    end else mdl_write(32, wdata, 4'hF);
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 || bid !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_mid outputs got awready=%b wready=%b bvalid=%b bresp=%b bid=%h want 1 0 0 00 0",
               awready, wready, bvalid, bresp, bid);
    end
    tick();
    aresetn = 1'b1;
    tick();
    check_word(32, "reset_mid_kept");
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wr_burst(4'h6, 32'h200, 3, 2, 1, 3, 0, "after_reset");
  endtask

  task automatic test_random();
    int size, burst, len, wl, r;
    bit bad_wrap;
    logic [31:0] addr;
    for (int t = 0; t < 60; t++) begin
      r     = $urandom_range(0, 9);
      size  = (r < 9) ? (r % 3) : $urandom_range(3, 7);
      burst = $urandom_range(0, 3);
      len   = $urandom_range(0, 15);
      wl    = ($urandom_range(0, 4) != 0) ? len : $urandom_range(0, 15);
      bad_wrap = (burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15);
      addr  = bad_wrap ? 32'($urandom_range(0, 32'h2FF)) : 32'($urandom_range(0, 32'h4FF));
      addr  = (addr >> size) << size;
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = bad_wrap ? 4'h0 : 4'($urandom_range(0, 15));
      end
      wr_burst(4'($urandom_range(0, 15)), addr, len, size, burst, wl,
               $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_final_sweep();
    for (int k = 0; k < 256; k++) check_word(k, "sweep");
  endtask

  initial begin
    test_reset();
    test_init();
    test_incr();
    test_wrap();
    test_fixed();
    test_oob();
    test_back_pressure();
    test_reset_mid();
    test_random();
    test_final_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
